// File: rtl/ddr_ctl2_cmd.sv
// ddr_ctl2_cmd: instruction front-end that stages address/data bytes and queues read/write commands to a valid/ready memory backend.
// Optional sticky error reporting under `DDRCTL2_ERR_EN; commands reach mem_req one cycle after acceptance, ready drops while bursting or full.

module ddr_ctl2_cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_dat,
   input  logic                   i_pop,
   output logic [W-1:0]           o_dat,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge i_clock) begin
      if (i_push) r_mem[r_wr_ptr] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

module ddr_ctl2_cmd #(
   parameter int ADDR_BYTES = 4,
   parameter int DATA_BYTES = 4,
   parameter int CMD_DEPTH  = 4
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic [11:0]             i_inst,
   input  logic                    i_inst_en,
   output logic                    o_ready,
   output logic [8*DATA_BYTES-1:0] o_page,
   output logic                    o_page_valid,
   output logic                    o_error,
   output logic                    o_mem_req_valid,
   input  logic                    i_mem_req_ready,
   output logic                    o_mem_req_we,
   output logic [8*ADDR_BYTES-1:0] o_mem_req_addr,
   output logic [8*DATA_BYTES-1:0] o_mem_req_data,
   input  logic                    i_mem_rsp_valid,
   input  logic [8*DATA_BYTES-1:0] i_mem_rsp_data
);
   localparam int ADDR_W = 8*ADDR_BYTES;
   localparam int DATA_W = 8*DATA_BYTES;
   localparam int CNT_W  = $clog2(CMD_DEPTH) + 1;

   localparam logic [3:0] OP_LA  = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_WRP = 4'h3;
   localparam logic [3:0] OP_RDP = 4'h4;
   localparam logic [3:0] OP_RDB = 4'h5;
   localparam logic [3:0] OP_CLR = 4'h6;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_data_q;
   logic [ADDR_W-1:0] r_burst_addr;
   logic [7:0]        r_burst_cnt;
   logic [DATA_W-1:0] r_page;
   logic              r_page_valid;

   logic [3:0]        w_op;
   logic [7:0]        w_imm;
   logic              w_exec;
   logic              w_full;
   logic              w_enq;
   logic              w_deq;
   cmd_t              w_enq_cmd;
   cmd_t              w_head;
   logic [CNT_W-1:0]  w_count;
   logic [ADDR_W-1:0] w_burst_next;

   assign w_op         = i_inst[11:8];
   assign w_imm        = i_inst[7:0];
   assign w_full       = (w_count == CNT_W'(CMD_DEPTH));
   assign o_ready      = (r_state == S_IDLE) && !w_full;
   assign w_exec       = i_inst_en && o_ready;
   assign w_burst_next = r_burst_addr + ADDR_W'(1);

   // Burst enqueues take priority; o_ready is low then, so no instruction competes.
   always_comb begin
      w_enq     = 1'b0;
      w_enq_cmd = '0;
      if (r_state == S_BURST) begin
         w_enq          = !w_full;
         w_enq_cmd.addr = r_burst_addr;
      end else if (w_exec && (w_op == OP_WRP || w_op == OP_RDP)) begin
         w_enq          = 1'b1;
         w_enq_cmd.we   = (w_op == OP_WRP);
         w_enq_cmd.addr = r_addr_q;
         w_enq_cmd.data = (w_op == OP_WRP) ? r_data_q : '0;
      end
   end

   assign w_deq = o_mem_req_valid && i_mem_req_ready;

   ddr_ctl2_cmd_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_push    (w_enq),
      .i_dat     (w_enq_cmd),
      .i_pop     (w_deq),
      .o_dat     (w_head),
      .o_count   (w_count)
   );

   assign o_mem_req_valid = (w_count != '0);
   assign o_mem_req_we    = w_head.we;
   assign o_mem_req_addr  = w_head.addr;
   assign o_mem_req_data  = w_head.data;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_addr_q     <= '0;
         r_data_q     <= '0;
         r_burst_addr <= '0;
         r_burst_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_exec) begin
                  case (w_op)
                     OP_LA:  r_addr_q <= ADDR_W'({r_addr_q, w_imm});
                     OP_LD:  r_data_q <= DATA_W'({r_data_q, w_imm});
                     OP_RDB: begin
                        r_burst_cnt  <= w_imm;
                        r_burst_addr <= r_addr_q;
                        r_state      <= S_BURST;
                     end
                     OP_CLR: begin
                        r_addr_q <= '0;
                        r_data_q <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            S_BURST: begin
               if (!w_full) begin
                  r_burst_addr <= w_burst_next;
                  if (r_burst_cnt == 8'd0) begin
                     r_addr_q <= w_burst_next;
                     r_state  <= S_IDLE;
                  end else begin
                     r_burst_cnt <= r_burst_cnt - 8'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_page       <= '0;
         r_page_valid <= 1'b0;
      end else begin
         r_page_valid <= i_mem_rsp_valid;
         if (i_mem_rsp_valid) r_page <= i_mem_rsp_data;
      end
   end

   assign o_page       = r_page;
   assign o_page_valid = r_page_valid;

`ifdef DDRCTL2_ERR_EN
   logic r_error;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_error <= 1'b0;
      end else if (w_exec && w_op == OP_CLR) begin
         r_error <= 1'b0;
      end else if ((w_exec && w_op > OP_CLR) || (i_inst_en && !o_ready)) begin
         r_error <= 1'b1;
      end
   end

   assign o_error = r_error;
`else
   assign o_error = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_ctl2_cmd.sv
// Bench for ddr_ctl2_cmd: directed vector table, hand-written corner sequences and a random run against a queue-based reference.
module tb_ddr_ctl2_cmd;
   localparam int DEPTH = 4;
`ifdef DDRCTL2_ERR_EN
   localparam bit ERR_EXP = 1'b1;
`else
   localparam bit ERR_EXP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [11:0] inst;
   logic        inst_en;
   logic        ready;
   logic [31:0] page;
   logic        page_valid;
   logic        error;
   logic        req_valid;
   logic        mrdy;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        rspv;
   logic [31:0] rspd;

   ddr_ctl2_cmd #(.ADDR_BYTES(4), .DATA_BYTES(4), .CMD_DEPTH(DEPTH)) dut (
      .i_clock         (clk),
      .i_reset_n       (rst_n),
      .i_inst          (inst),
      .i_inst_en       (inst_en),
      .o_ready         (ready),
      .o_page          (page),
      .o_page_valid    (page_valid),
      .o_error         (error),
      .o_mem_req_valid (req_valid),
      .i_mem_req_ready (mrdy),
      .o_mem_req_we    (req_we),
      .o_mem_req_addr  (req_addr),
      .o_mem_req_data  (req_data),
      .i_mem_rsp_valid (rspv),
      .i_mem_rsp_data  (rspd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue of commands plus the staging values.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mcmd_t;

   mcmd_t       mq[$];
   logic [31:0] m_addr, m_data, m_baddr, m_page;
   int          m_left;
   bit          m_burst;
   logic        m_err, m_pv;

   task automatic model_reset();
      mq.delete();
      m_addr = 0; m_data = 0; m_baddr = 0; m_page = 0;
      m_left = 0; m_burst = 0; m_err = 0; m_pv = 0;
   endtask

   task automatic model_compare();
      chk("m_ready", 32'(ready), 32'(!m_burst && mq.size() < DEPTH));
      chk("m_req_valid", 32'(req_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("m_req_we", 32'(req_we), 32'(mq[0].we));
         chk("m_req_addr", req_addr, mq[0].addr);
         if (mq[0].we) chk("m_req_data", req_data, mq[0].data);
      end
      chk("m_page", page, m_page);
      chk("m_page_valid", 32'(page_valid), 32'(m_pv));
      chk("m_error", 32'(error), 32'(m_err));
   endtask

   task automatic model_step();
      mcmd_t      c;
      bit         enq, deq, rdy;
      logic [3:0] op;
      logic [7:0] imm;
      if (!rst_n) return;
      op  = inst[11:8];
      imm = inst[7:0];
      rdy = !m_burst && (mq.size() < DEPTH);
      deq = (mq.size() > 0) && mrdy;
      enq = 0;
      c   = '0;
      if (m_burst) begin
         if (mq.size() < DEPTH) begin
            enq    = 1;
            c.addr = m_baddr;
            m_baddr = m_baddr + 1;
            if (m_left == 0) begin
               m_burst = 0;
               m_addr  = m_baddr;
            end else m_left--;
         end
      end else if (inst_en && rdy) begin
         case (op)
            4'h0: ;
            4'h1: m_addr = {m_addr[23:0], imm};
            4'h2: m_data = {m_data[23:0], imm};
            4'h3: begin enq = 1; c = {1'b1, m_addr, m_data}; end
            4'h4: begin enq = 1; c = {1'b0, m_addr, 32'h0}; end
            4'h5: begin m_burst = 1; m_left = int'(imm); m_baddr = m_addr; end
            4'h6: begin m_addr = 0; m_data = 0; m_err = 0; end
            default: if (ERR_EXP) m_err = 1;
         endcase
      end
      if (inst_en && !rdy && ERR_EXP) m_err = 1;
      m_pv = rspv;
      if (rspv) m_page = rspd;
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(c);
   endtask

   // One clock: check and advance the model at the falling edge, return 1 after the rising edge.
   task automatic cyc();
      @(negedge clk);
      model_compare();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [11:0] inst;
      logic        en, mrdy, rspv;
      logic [31:0] rspd;
      logic        e_ready, e_valid, e_we;
      logic [31:0] e_addr, e_data, e_page;
      logic        e_pv, e_err;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [11:0] i, input logic en, input logic mr, input logic rv,
                      input logic [31:0] rd, input logic er, input logic ev, input logic ew,
                      input logic [31:0] ea, input logic [31:0] ed, input logic [31:0] ep,
                      input logic epv, input logic ee);
      vec_t v;
      v.inst = i; v.en = en; v.mrdy = mr; v.rspv = rv; v.rspd = rd;
      v.e_ready = er; v.e_valid = ev; v.e_we = ew; v.e_addr = ea; v.e_data = ed;
      v.e_page = ep; v.e_pv = epv; v.e_err = ee;
      vt.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          got;
      logic [31:0] rec_d [4];
      logic [31:0] rec_a [4];
      logic        rec_w [4];
      logic [31:0] exp_a [4];

      rst_n = 0; inst = 0; inst_en = 0; mrdy = 1; rspv = 0; rspd = 0;
      model_reset();
      #2;
      chk("rst_ready", 32'(ready), 32'(1));
      chk("rst_valid", 32'(req_valid), 32'(0));
      chk("rst_page", page, 32'h0);
      chk("rst_pv", 32'(page_valid), 32'(0));
      chk("rst_err", 32'(error), 32'(0));
      cyc(); cyc();
      rst_n = 1;

      // Expected outputs are those seen after the clock edge that consumes the inputs.
      add(12'h112, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h13F, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h12B, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h100, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h2AA, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h2BB, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h2CC, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h2DD, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h300, 1, 1, 0, 0, 1, 1, 1, 32'h123F2B00, 32'hAABBCCDD, 0, 0, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h400, 1, 0, 0, 0, 1, 1, 0, 32'h123F2B00, 0, 0, 0, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(12'h000, 0, 1, 1, 32'hAABBCCDD, 1, 0, 0, 0, 0, 32'hAABBCCDD, 1, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'hAABBCCDD, 0, 0);
      add(12'hF10, 1, 1, 0, 0, 1, 0, 0, 0, 0, 32'hAABBCCDD, 0, ERR_EXP);
      add(12'h300, 1, 1, 0, 0, 1, 1, 1, 32'h123F2B00, 32'hAABBCCDD, 32'hAABBCCDD, 0, ERR_EXP);
      add(12'h600, 1, 1, 0, 0, 1, 0, 0, 0, 0, 32'hAABBCCDD, 0, 0);
      add(12'h300, 1, 1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'hAABBCCDD, 0, 0);
      add(12'h000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'hAABBCCDD, 0, 0);

      foreach (vt[i]) begin
         inst = vt[i].inst; inst_en = vt[i].en; mrdy = vt[i].mrdy;
         rspv = vt[i].rspv; rspd = vt[i].rspd;
         cyc();
         chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vt[i].e_ready));
         chk($sformatf("v%0d_valid", i), 32'(req_valid), 32'(vt[i].e_valid));
         if (vt[i].e_valid) begin
            chk($sformatf("v%0d_we", i), 32'(req_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_addr", i), req_addr, vt[i].e_addr);
            if (vt[i].e_we) chk($sformatf("v%0d_data", i), req_data, vt[i].e_data);
         end
         chk($sformatf("v%0d_page", i), page, vt[i].e_page);
         chk($sformatf("v%0d_pv", i), 32'(page_valid), 32'(vt[i].e_pv));
         chk($sformatf("v%0d_err", i), 32'(error), 32'(vt[i].e_err));
      end
      inst_en = 0; rspv = 0;

      // Fill the queue with a stalled backend, then drop a fifth write.
      mrdy = 0;
      for (int i = 0; i < 4; i++) begin
         inst = {4'h2, 8'(i + 1)}; inst_en = 1; cyc();
         inst = 12'h300; cyc();
      end
      chk("full_ready", 32'(ready), 32'(0));
      inst = 12'h300; inst_en = 1; cyc();
      chk("drop_err", 32'(error), 32'(ERR_EXP));
      inst_en = 0; mrdy = 1; got = 0;
      for (int k = 0; k < 20; k++) begin
         if (req_valid) begin
            if (got < 4) begin rec_d[got] = req_data; rec_w[got] = req_we; end
            got++;
         end
         cyc();
      end
      chk("full_nwrites", 32'(got), 32'(4));
      chk("full_w0", rec_d[0], 32'h00000001);
      chk("full_w1", rec_d[1], 32'h00000102);
      chk("full_w2", rec_d[2], 32'h00010203);
      chk("full_w3", rec_d[3], 32'h01020304);
      chk("full_we", 32'({rec_w[0], rec_w[1], rec_w[2], rec_w[3]}), 32'hF);

      // Burst across the top of the address space.
      inst_en = 1;
      inst = 12'h600; cyc();
      inst = 12'h1FF; cyc();
      inst = 12'h1FF; cyc();
      inst = 12'h1FF; cyc();
      inst = 12'h1FE; cyc();
      inst = 12'h503; cyc();
      chk("burst_ready0", 32'(ready), 32'(0));
      inst_en = 0; got = 0;
      for (int k = 0; k < 30; k++) begin
         if (req_valid) begin
            if (got < 3) chk($sformatf("burst_ready_%0d", got), 32'(ready), 32'(0));
            if (got < 4) rec_a[got] = req_addr;
            got++;
         end
         cyc();
      end
      exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
      chk("burst_nreads", 32'(got), 32'(4));
      for (int k = 0; k < 4; k++) chk($sformatf("burst_addr%0d", k), rec_a[k], exp_a[k]);
      mrdy = 0; inst = 12'h400; inst_en = 1; cyc();
      chk("burst_after_valid", 32'(req_valid), 32'(1));
      chk("burst_after_addr", req_addr, 32'h00000002);
      inst_en = 0; mrdy = 1; cyc();

      // Reset in the middle of a stalled burst.
      mrdy = 0; inst = 12'h505; inst_en = 1; cyc();
      inst_en = 0; cyc(); cyc();
      chk("midrst_pre_valid", 32'(req_valid), 32'(1));
      rst_n = 0;
      #1;
      chk("midrst_valid", 32'(req_valid), 32'(0));
      chk("midrst_ready", 32'(ready), 32'(1));
      chk("midrst_page", page, 32'h0);
      chk("midrst_err", 32'(error), 32'(0));
      model_reset();
      cyc();
      rst_n = 1; mrdy = 1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk($sformatf("postrst_valid%0d", k), 32'(req_valid), 32'(0));
      end

      // Random traffic against the reference.
      for (int k = 0; k < 3000; k++) begin
         int r;
         r = int'($urandom_range(0, 19));
         inst[11:8] = (r < 16) ? 4'(r) : 4'h3;
         inst[7:0]  = (inst[11:8] == 4'h5) ? 8'($urandom_range(0, 6)) : 8'($urandom);
         inst_en = ($urandom_range(0, 9) < 7);
         mrdy    = ($urandom_range(0, 9) < 6);
         rspv    = ($urandom_range(0, 4) == 0);
         rspd    = $urandom;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
